// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit in front of the byte-addressed data memory:
// access-size encodings, FSM state enum and a byte-count helper.
package lsu_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  // Request sequencing states
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_e;

  // Number of bytes touched by an access; the reserved size behaves as a word
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Lane logic for the load/store unit: zero/sign extension of load data and
// low-lane merge of store data into the word read back from memory.
// Purely combinational; the reserved size is handled like a word.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic sign_b;
  logic sign_h;

  // Fill bit for the upper lanes: zero for unsigned loads, top data bit otherwise
  assign sign_b = ~uns_i & rdata_i[7];
  assign sign_h = ~uns_i & rdata_i[15];

  // Extend the loaded value and build the read-modify-write word by size
  always_comb begin
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_B: begin
        load_o  = {{24{sign_b}}, rdata_i[7:0]};
        merge_o = {rdata_i[31:8], wdata_i[7:0]};
      end
      SZ_H: begin
        load_o  = {{16{sign_h}}, rdata_i[15:0]};
        merge_o = {rdata_i[31:16], wdata_i[15:0]};
      end
      default: begin
        load_o  = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dmem_port.sv
// Load/store unit directly upstream of a byte-addressed data memory that only
// writes whole words. One request in flight; byte and halfword stores become a
// read-modify-write so neighbouring bytes survive.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned, reserved-size
// and out-of-range accesses with a one-cycle error response.
module lsu_dmem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  lsu_state_e        state_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              dm_we_q;

  logic [31:0]       load_d;
  logic [31:0]       merge_d;
  logic              acc_err;
  logic              is_sub_word;

  // Extension and merge are driven from the latched request and live memory data
  lsu_extend u_extend (
    .size_i  (size_q),
    .uns_i   (uns_q),
    .rdata_i (dm_rdata),
    .wdata_i (wdata_q),
    .load_o  (load_d),
    .merge_o (merge_d)
  );

  assign is_sub_word = (req_size == SZ_B) || (req_size == SZ_H);

`ifdef LSU_ALIGN_CHECK_EN
  logic [ADDR_W:0] last_byte;
  logic            misaligned;

  // Address of the final byte touched, one bit wider so it cannot wrap
  assign last_byte  = {1'b0, req_addr} + (ADDR_W+1)'(bytes_of(req_size)) - (ADDR_W+1)'(1);
  assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign acc_err    = misaligned || (req_size == SZ_RSV) ||
                      (last_byte >= (ADDR_W+1)'(MEM_BYTES));
`else
  logic unused_mem_bytes;

  // Memory size only matters to the range check, which is compiled out here
  assign acc_err          = 1'b0;
  assign unused_mem_bytes = ^32'(MEM_BYTES);
`endif

  // Request sequencer: latches the request and registers every memory/response output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      dm_we_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdata_q <= '0;
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (acc_err) begin
              // Rejected accesses never touch memory and answer next cycle
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we) begin
              state_q <= LOAD;
            end else if (is_sub_word) begin
              state_q <= RMW_RD;
            end else begin
              state_q <= WRITE;
              dm_we_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          rdata_q      <= load_d;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RMW_RD: begin
          // Old word with the store lanes replaced becomes the write data
          wdata_q <= merge_d;
          state_q <= WRITE;
          dm_we_q <= 1'b1;
        end
        WRITE: begin
          dm_we_q      <= 1'b0;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          rdata_q      <= '0;
          state_q      <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          dm_we_q      <= 1'b0;
          rdata_q      <= '0;
        end
      endcase
    end
  end

  // Ready is gated by reset so it reads low while reset is held and high on the first cycle after
  assign req_ready  = rst && (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Testbench for lsu_dmem_port: byte-array memory, reference byte image with a
// request-level expectation per access, plus directed literal checks.
module tb_lsu_dmem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  always #5 clk = ~clk;

  lsu_dmem_port #(.ADDR_W(32), .MEM_BYTES(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata)
  );

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Memory: combinational read of four bytes, whole-word write on the edge
  always_comb begin
    dm_rdata = {mem[dm_addr[7:0] + 8'd3], mem[dm_addr[7:0] + 8'd2],
                mem[dm_addr[7:0] + 8'd1], mem[dm_addr[7:0]]};
  end

  always @(posedge clk) begin
    if (dm_we) begin
      for (int i = 0; i < 4; i++) mem[dm_addr[7:0] + 8'(i)] <= dm_wdata[8*i +: 8];
    end
  end

  // Expectation for the request in flight
  int          n = 0;
  logic        pend = 1'b0;
  int          acc_n = 0;
  int          lat = 0;
  int          e_nb = 0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_data = '0;
  logic        e_err = 1'b0;
  logic        e_store = 1'b0;
  logic [31:0] e_wdata = '0;
  logic [31:0] e_stdata = '0;
  logic        rv_e;
  logic        we_e;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_lat = 0;
  int          resp_cnt = 0;
  int          we_cnt = 0;
  int          acc_cnt = 0;
  int          acc_hist[$];
  logic [7:0]  lanes [4];

  always @(negedge clk) begin
    n++;
    if (resp_valid) resp_cnt++;
    if (dm_we) we_cnt++;
    if (!rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_dm_we", dm_we, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_dm_addr", dm_addr, 0);
      chk("rst_dm_wdata", dm_wdata, 0);
      pend = 1'b0;
    end else begin
      rv_e = pend && (n == acc_n + lat);
      we_e = pend && e_store && (n == acc_n + lat - 1);
      chk("req_ready", req_ready, !pend);
      chk("resp_valid", resp_valid, rv_e);
      chk("resp_err", resp_err, rv_e ? e_err : 1'b0);
      chk("resp_rdata", resp_rdata, rv_e ? e_data : 32'h0);
      chk("dm_we", dm_we, we_e);
      if (pend && n > acc_n) chk("dm_addr", dm_addr, e_addr);
      if (we_e) begin
        chk("dm_wdata", dm_wdata, e_wdata);
        for (int i = 0; i < e_nb; i++) ref_mem[8'(e_addr + 32'(i))] = e_stdata[8*i +: 8];
      end
      if (rv_e) begin
        last_rdata = resp_rdata;
        last_err   = resp_err;
        last_lat   = n - acc_n;
        pend       = 1'b0;
      end
      if (req_valid && req_ready) begin
        acc_n = n;
        acc_cnt++;
        acc_hist.push_back(n);
        pend     = 1'b1;
        e_addr   = req_addr;
        e_stdata = req_wdata;
        e_nb     = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
`ifdef LSU_ALIGN_CHECK_EN
        e_err = (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                (req_size == 2'b11) ||
                (longint'(req_addr) + longint'(e_nb) - 1 >= 256);
`else
        e_err = 1'b0;
`endif
        e_store = 1'b0;
        e_data  = '0;
        e_wdata = '0;
        if (e_err) begin
          lat = 1;
        end else if (!req_we) begin
          lat = 2;
          for (int i = 0; i < e_nb; i++) e_data[8*i +: 8] = ref_mem[8'(req_addr + 32'(i))];
          if (e_nb < 4 && !req_unsigned && e_data[8*e_nb-1])
            for (int i = 8*e_nb; i < 32; i++) e_data[i] = 1'b1;
        end else begin
          e_store = 1'b1;
          lat = (e_nb == 4) ? 2 : 3;
          for (int i = 0; i < 4; i++) lanes[i] = ref_mem[8'(req_addr + 32'(i))];
          for (int i = 0; i < e_nb; i++) lanes[i] = req_wdata[8*i +: 8];
          e_wdata = {lanes[3], lanes[2], lanes[1], lanes[0]};
        end
      end
    end
  end

  task automatic put_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a + 8'(i)]     = w[8*i +: 8];
      ref_mem[a + 8'(i)] = w[8*i +: 8];
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    bit got;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    chk("accept_seen", got, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; break; end
    end
    chk("resp_seen", got, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int we0, r0, a0, bad;
    bit got;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    put_word(8'h10, 32'h8899AABB);
    put_word(8'h14, 32'h11223344);
    put_word(8'h30, 32'hCAFEF00D);
    put_word(8'h00, 32'h04030201);
    put_word(8'hFC, 32'hA0B0C0D0);

    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    do_req(0, 2'b00, 0, 32'h10, 0);
    $display("LB   0x10 -> %h lat %0d", last_rdata, last_lat);
    chk("lb_s_data", last_rdata, 32'hFFFFFFBB);
    chk("lb_s_lat", last_lat, 2);
    do_req(0, 2'b00, 1, 32'h10, 0);
    $display("LBU  0x10 -> %h", last_rdata);
    chk("lbu_data", last_rdata, 32'h000000BB);

    we0 = we_cnt;
    do_req(1, 2'b00, 0, 32'h11, 32'hFFFFFF5A);
    $display("SB   0x11 <- 5A lat %0d", last_lat);
    chk("sb_lat", last_lat, 3);
    chk("sb_we_pulses", we_cnt - we0, 1);
    chk("sb_rdata", last_rdata, 0);
    do_req(0, 2'b10, 0, 32'h10, 0);
    $display("LW   0x10 -> %h", last_rdata);
    chk("lw_after_sb", last_rdata, 32'h88995ABB);
    do_req(0, 2'b00, 1, 32'h14, 0);
    $display("LBU  0x14 -> %h", last_rdata);
    chk("lbu_neighbor", last_rdata, 32'h00000044);

    we0 = we_cnt;
    do_req(1, 2'b10, 0, 32'h20, 32'hDEADBEEF);
    $display("SW   0x20 <- DEADBEEF lat %0d", last_lat);
    chk("sw_lat", last_lat, 2);
    chk("sw_we_pulses", we_cnt - we0, 1);
    do_req(0, 2'b01, 0, 32'h20, 0);
    $display("LH   0x20 -> %h", last_rdata);
    chk("lh_s_data", last_rdata, 32'hFFFFBEEF);
    do_req(0, 2'b01, 1, 32'h20, 0);
    $display("LHU  0x20 -> %h", last_rdata);
    chk("lhu_data", last_rdata, 32'h0000BEEF);

    do_req(1, 2'b01, 0, 32'h22, 32'h00001234);
    $display("SH   0x22 <- 1234 lat %0d", last_lat);
    chk("sh_lat", last_lat, 3);
    do_req(0, 2'b10, 0, 32'h20, 0);
    $display("LW   0x20 -> %h", last_rdata);
    chk("lw_after_sh", last_rdata, 32'h1234BEEF);
    do_req(0, 2'b11, 0, 32'h20, 0);
    $display("L11  0x20 -> %h err %0d", last_rdata, last_err);
`ifndef LSU_ALIGN_CHECK_EN
    chk("l_rsv_as_word", last_rdata, 32'h1234BEEF);
`else
    chk("l_rsv_err", last_err, 1);
`endif

    // Two loads with req_valid held high
    a0 = acc_cnt; r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    got = 0;
    for (int i = 0, seen = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin seen++; if (seen == 2) begin got = 1; break; end end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < 20 && resp_cnt - r0 < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    $display("B2B  accepts %0d resps %0d", acc_cnt - a0, resp_cnt - r0);
    chk("b2b_second_ready", got, 1);
    chk("b2b_accepts", acc_cnt - a0, 2);
    chk("b2b_resps", resp_cnt - r0, 2);
    if (acc_hist.size() >= 2) chk("b2b_gap", acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2], 3);

    // Reset while the byte store is reading back the old word
    we0 = we_cnt; r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h30; req_wdata = 32'h77;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    @(posedge clk); #1 req_valid = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    $display("RST  mid-RMW ready %0d we %0d resp %0d", req_ready, we_cnt - we0, resp_cnt - r0);
    chk("rst_store_accepted", got, 1);
    chk("rst_ready_after", req_ready, 1);
    chk("rst_no_we", we_cnt - we0, 0);
    chk("rst_no_resp", resp_cnt - r0, 0);
    @(posedge clk); #1;
    do_req(0, 2'b10, 0, 32'h30, 0);
    $display("LW   0x30 -> %h", last_rdata);
    chk("rst_mem_kept", last_rdata, 32'hCAFEF00D);

    do_req(0, 2'b01, 0, 32'h21, 0);
    $display("LH   0x21 -> %h err %0d lat %0d", last_rdata, last_err, last_lat);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lh_odd_err", last_err, 1);
    chk("lh_odd_data", last_rdata, 0);
    chk("lh_odd_lat", last_lat, 1);
`else
    chk("lh_odd_err", last_err, 0);
    chk("lh_odd_data", last_rdata, 32'h000034BE);
    chk("lh_odd_lat", last_lat, 2);
`endif

    do_req(0, 2'b10, 0, 32'hFE, 0);
    $display("LW   0xFE -> %h err %0d", last_rdata, last_err);
`ifndef LSU_ALIGN_CHECK_EN
    chk("lw_wrap", last_rdata, 32'h0201A0B0);
`endif

    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
